// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the IF/MEM memory arbiter:
// FSM state encodings, mem_len codes and a byte-count helper.
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IF_RD  = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] MEMLEN_B = 2'b00;
    localparam logic [1:0] MEMLEN_H = 2'b01;
    localparam logic [1:0] MEMLEN_W = 2'b10;

    localparam logic [2:0] IF_NBYTES = 3'd4;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        unique case (len)
            MEMLEN_B: n = 3'd1;
            MEMLEN_H: n = 3'd2;
            MEMLEN_W: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the RAM.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output mem_done, mem_rdata,
        output ram_a, ram_dout, ram_wr,
        input  ram_din,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  mem_done, mem_rdata,
        input  ram_a, ram_dout, ram_wr,
        output ram_din,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM between IF and MEM stages.
// Define MEMARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    logic [2:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nb_q, nb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;

    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;

    logic              if_ok;
    logic              grant_mem;
    logic              grant_if;
    logic [1:0]        rd_lane;
    logic [ADDR_W-1:0] cur_addr;

`ifdef MEMARB_RR_EN
    // 0: MEM holds priority, 1: IF holds priority
    logic rr_q, rr_d;

    assign grant_mem = bus.mem_req && (!if_ok || !rr_q);
`else
    assign grant_mem = bus.mem_req;
`endif

    assign if_ok    = bus.if_req && !bus.if_flush;
    assign grant_if = if_ok && !grant_mem;

    // ram_din lags ram_a by one cycle, so reads land two counts behind
    assign rd_lane  = cnt_q[1:0] - 2'd2;
    assign cur_addr = addr_q + ADDR_W'(cnt_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nb_d        = nb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
`ifdef MEMARB_RR_EN
        rr_d        = rr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                buf_d = '0;
                if (grant_mem) begin
                    state_d = bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                    addr_d  = bus.mem_addr;
                    nb_d    = len_bytes(bus.mem_len);
                    wdata_d = bus.mem_wdata;
`ifdef MEMARB_RR_EN
                    rr_d    = 1'b1;
`endif
                end else if (grant_if) begin
                    state_d = ST_IF_RD;
                    addr_d  = bus.if_addr;
                    nb_d    = IF_NBYTES;
`ifdef MEMARB_RR_EN
                    rr_d    = 1'b0;
`endif
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if (state_q == ST_IF_RD && bus.if_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < nb_q) begin
                        ram_a_d = cur_addr;
                    end
                    if (cnt_q >= 3'd2) begin
                        buf_d[{rd_lane, 3'b000} +: 8] = bus.ram_din;
                    end
                    if (cnt_q == nb_q + 3'd1) begin
                        state_d = ST_DONE;
                        if (state_q == ST_IF_RD) begin
                            if_data_d = buf_d;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = buf_d;
                            mem_done_d  = 1'b1;
                        end
                    end
                end
            end

            ST_MEM_WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < nb_q) begin
                    ram_a_d    = cur_addr;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                end else begin
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            nb_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nb_q        <= nb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
`ifdef MEMARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide RAM model.
// Honours MEMARB_RR_EN for the simultaneous-request grant order.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] ram [0:4095];

    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_a[11:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          grant_q [$];
    int          done_k  [$];
    int          done_c  [$];
    logic [31:0] done_d  [$];
    logic [31:0] wr_a    [$];
    logic [7:0]  wr_d    [$];
    int          wr_c    [$];
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.busy && !busy_prev) grant_q.push_back(cyc);
        busy_prev <= bus.busy;
        if (bus.mem_done) begin
            done_k.push_back(0);
            done_c.push_back(cyc);
            done_d.push_back(bus.mem_rdata);
        end
        if (bus.if_done) begin
            done_k.push_back(1);
            done_c.push_back(cyc);
            done_d.push_back(bus.if_data);
        end
        if (bus.ram_wr) begin
            wr_a.push_back(bus.ram_a);
            wr_d.push_back(bus.ram_dout);
            wr_c.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        @(posedge clk);
        grant_q.delete();
        done_k.delete();
        done_c.delete();
        done_d.delete();
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (done_k.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 64'(done_k.size() >= n), 64'd1);
    endtask

    int exp_k [4];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h200] = 8'hA5;
        ram[12'h201] = 8'h77;
        ram[12'h202] = 8'h11;
        ram[12'h203] = 8'h22;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dones", 64'({bus.if_done, bus.mem_done}), 64'd0);
        chk("rst_data", {bus.if_data, bus.mem_rdata}, 64'd0);
        chk("rst_ram", 64'({bus.ram_a, bus.ram_dout, bus.ram_wr}), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // IF-only read
        clr();
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        wait_dones("t1_timeout", 1, 40);
        @(negedge clk);
        bus.if_req = 1'b0;
        chk("t1_kind", 64'(done_k[0]), 64'd1);
        chk("t1_data", 64'(done_d[0]), 64'h13);
        chk("t1_lat", 64'(done_c[0] - grant_q[0]), 64'd6);
        repeat (4) @(negedge clk);

        // simultaneous requests, MEM byte load wins
        clr();
        @(negedge clk);
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h100;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'b00;
        bus.mem_addr = 32'h200;
        wait_dones("t2_timeout_a", 1, 40);
        @(negedge clk);
        bus.mem_req = 1'b0;
        wait_dones("t2_timeout_b", 2, 40);
        @(negedge clk);
        bus.if_req = 1'b0;
        chk("t2_first", 64'(done_k[0]), 64'd0);
        chk("t2_rdata", 64'(done_d[0]), 64'h0000_00A5);
        chk("t2_mlat", 64'(done_c[0] - grant_q[0]), 64'd3);
        chk("t2_gap", 64'(grant_q[1] - done_c[0]), 64'd2);
        chk("t2_second", 64'(done_k[1]), 64'd1);
        chk("t2_ilat", 64'(done_c[1] - grant_q[1]), 64'd6);
        chk("t2_hold", 64'(bus.mem_rdata), 64'h0000_00A5);
        repeat (4) @(negedge clk);

        // halfword store crossing 0x3FF -> 0x400
        clr();
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b01;
        bus.mem_addr  = 32'h3FF;
        bus.mem_wdata = 32'h1234_BEEF;
        wait_dones("t3_timeout", 1, 40);
        @(negedge clk);
        bus.mem_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_nwr", 64'(wr_a.size()), 64'd2);
        chk("t3_w0", {32'(wr_a[0]), 32'(wr_d[0])}, {32'h3FF, 32'hEF});
        chk("t3_w1", {32'(wr_a[1]), 32'(wr_d[1])}, {32'h400, 32'hBE});
        chk("t3_wlat", 64'(wr_c[0] - grant_q[0]), 64'd1);
        chk("t3_dlat", 64'(done_c[0] - grant_q[0]), 64'd3);
        chk("t3_ram", 64'({ram[12'h3FF], ram[12'h400]}), 64'hEFBE);

        // flush during IF_RD with MEM pending
        clr();
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'b10;
        bus.mem_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        chk("t4_idle", 64'(bus.busy), 64'd0);
        wait_dones("t4_timeout", 1, 40);
        @(negedge clk);
        bus.mem_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_ndone", 64'(done_k.size()), 64'd1);
        chk("t4_kind", 64'(done_k[0]), 64'd0);
        chk("t4_rdata", 64'(done_d[0]), 64'h2211_77A5);
        chk("t4_regrant", 64'(grant_q[1] - grant_q[0]), 64'd4);
        chk("t4_lat", 64'(done_c[0] - grant_q[1]), 64'd6);
        chk("t4_ifhold", 64'(bus.if_data), 64'h13);

        // flush in IDLE suppresses the IF grant
        clr();
        @(negedge clk);
        bus.if_req   = 1'b1;
        bus.if_flush = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_ngrant", 64'(grant_q.size()), 64'd0);
        bus.if_req   = 1'b0;
        bus.if_flush = 1'b0;

        // reset in the middle of a word store
        clr();
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'b10;
        bus.mem_addr  = 32'h300;
        bus.mem_wdata = 32'hDDCC_BBAA;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_byte1", 64'({bus.ram_wr, bus.ram_a}), {31'd0, 1'b1, 32'h301});
        rst = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_ram", 64'({bus.ram_a, bus.ram_dout, bus.ram_wr}), 64'd0);
        chk("t6_data", {bus.if_data, bus.mem_rdata}, 64'd0);
        chk("t6_dones", 64'({bus.if_done, bus.mem_done}), 64'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_nodone", 64'(done_k.size()), 64'd0);
        chk("t6_nwr", 64'(wr_a.size()), 64'd2);
        chk("t6_mem", 64'({ram[12'h300], ram[12'h301], ram[12'h302]}),
            64'hAABB00);

        // both ports requesting continuously
`ifdef MEMARB_RR_EN
        exp_k = '{0, 1, 0, 1};
`else
        exp_k = '{0, 0, 0, 0};
`endif
        clr();
        @(negedge clk);
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h100;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'b00;
        bus.mem_addr = 32'h200;
        wait_dones("t7_timeout", 4, 80);
        @(negedge clk);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t7_grant%0d", i), 64'(done_k[i]), 64'(exp_k[i]));
        end
        repeat (12) @(negedge clk);
        chk("t7_idle", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
